// File: rtl/wb_stage_pipelined.sv
// wb_stage_pipelined: MEM/WB pipeline register with byte-lane load filter, gated register-file write and EX forwarding tap.
// Optional WB_RETIRE_COUNTER_EN adds o_wb_retired, a count of retired valid instructions.
module wb_stage_pipelined #(
    parameter int BITS_SIZE      = 32,
    parameter int BITS_REGS      = 5,
    parameter int LINK_REG       = 31,
    parameter int HW_BITS        = 16,
    parameter int BYTE_BITS_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_regwrite,
    input  logic                 i_mem_to_reg,
    input  logic                 i_lui,
    input  logic                 i_jal,
    input  logic                 i_zero_extend,
    input  logic [1:0]           i_size_filterL,
    input  logic [1:0]           i_addr_lsb,
    input  logic [BITS_SIZE-1:0] i_dato_mem,
    input  logic [BITS_SIZE-1:0] i_alu,
    input  logic [BITS_SIZE-1:0] i_extension,
    input  logic [BITS_SIZE-1:0] i_pc8,
    input  logic [BITS_REGS-1:0] i_register_dst,
    output logic                 o_wb_write_en,
    output logic [BITS_REGS-1:0] o_wb_register_addr,
    output logic [BITS_SIZE-1:0] o_wb_data_write,
    output logic [BITS_SIZE-1:0] o_wb_data_write_ex,
    output logic                 o_wb_misalign
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [31:0]          o_wb_retired
`endif
);
    localparam logic [BITS_REGS-1:0] LINK = LINK_REG[BITS_REGS-1:0];

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 mem_to_reg;
        logic                 lui;
        logic                 jal;
        logic                 zero_extend;
        logic [1:0]           size;
        logic [1:0]           lsb;
        logic [BITS_SIZE-1:0] dato;
        logic [BITS_SIZE-1:0] alu;
        logic [BITS_SIZE-1:0] ext;
        logic [BITS_SIZE-1:0] pc8;
        logic [BITS_REGS-1:0] dst;
    } mw_t;

    mw_t mw_q, mw_d;
    logic [BYTE_BITS_SIZE-1:0] lane_b;
    logic [HW_BITS-1:0]        lane_h;
    logic [31:0]               lane_w;
    logic                      fill;
    logic [BITS_SIZE-1:0]      filt, data_to_reg, mem_data;

    always_comb begin
        mw_d = i_flush ? mw_t'('0) : i_stall ? mw_q : mw_t'{i_valid, i_regwrite, i_mem_to_reg, i_lui, i_jal,
            i_zero_extend, i_size_filterL, i_addr_lsb, i_dato_mem, i_alu, i_extension, i_pc8, i_register_dst};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) mw_q <= '0;
        else          mw_q <= mw_d;
    end

    assign lane_b = mw_q.dato[{mw_q.lsb, 3'b000} +: BYTE_BITS_SIZE];
    assign lane_h = mw_q.dato[{mw_q.lsb[1], 4'b0000} +: HW_BITS];
    assign lane_w = mw_q.dato[31:0];
    assign fill   = ~mw_q.zero_extend &
                    (mw_q.size[1] ? lane_w[31] : mw_q.size[0] ? lane_h[HW_BITS-1] : lane_b[BYTE_BITS_SIZE-1]);

    // Start from the extension fill, then overlay the selected lane.
    always_comb begin
        filt = {BITS_SIZE{fill}};
        if (mw_q.size[1])      filt[31:0]               = lane_w;
        else if (mw_q.size[0]) filt[HW_BITS-1:0]        = lane_h;
        else                   filt[BYTE_BITS_SIZE-1:0] = lane_b;
    end

    assign data_to_reg        = mw_q.lui ? mw_q.ext : filt;
    assign mem_data           = mw_q.mem_to_reg ? data_to_reg : mw_q.alu;
    assign o_wb_data_write_ex = mem_data;
    assign o_wb_data_write    = mw_q.jal ? mw_q.pc8 : mem_data;
    assign o_wb_register_addr = mw_q.jal ? LINK : mw_q.dst;
    assign o_wb_misalign      = mw_q.valid & mw_q.mem_to_reg & ~mw_q.lui & (mw_q.size == 2'b01) & mw_q.lsb[0];
    assign o_wb_write_en      = mw_q.valid & (mw_q.regwrite | mw_q.jal) & (|o_wb_register_addr) & ~o_wb_misalign;

`ifdef WB_RETIRE_COUNTER_EN
    logic [31:0] retired_q, retired_d;

    // A flush still lets the instruction currently in WB retire; only the incoming slot becomes a bubble.
    assign retired_d = retired_q + 32'(mw_q.valid & (i_flush | ~i_stall));

    always_ff @(posedge i_clk) begin
        if (!i_reset) retired_q <= '0;
        else          retired_q <= retired_d;
    end

    assign o_wb_retired = retired_q;
`endif
endmodule
